hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the MIPS32 five-stage core. It detects load-use hazards and taken control transfers, and sequences multi-cycle mul/div operations. From these it generates the PC/IF-ID/ID-EX write enables, the pipeline flushes and the `ex_stall` bubble request consumed by `ctrl_mux`. It also keeps a sticky mul/div timeout flag and a saturating stall-cycle performance counter.

## Interface
- MD_TIMEOUT, 64: max cycles spent in MD_WAIT before abort (2..2^CNT_W-1)
- CNT_W, 16: width of stall counter and timeout counter
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- ex_mem_read  in  1  instruction in EX is a load
- ex_rt  in  5  destination register of load in EX
- ex_jump  in  2  jump control of instruction in EX (nonzero = jump)
- ex_branch_taken  in  1  branch in EX resolved taken
- md_start  in  1  mul/div instruction present in EX (issue cycle)
- md_done  in  1  mul/div unit result valid this cycle
- pc_write  out  1  PC load enable
- if_id_write  out  1  IF/ID register enable
- id_ex_write  out  1  ID/EX register enable
- ex_stall  out  1  bubble request to ctrl_mux (zero ID controls)
- if_id_flush  out  1  clear IF/ID next edge
- id_ex_flush  out  1  clear ID/EX next edge
- ex_mem_flush  out  1  insert bubble into EX/MEM
- md_timeout  out  1  sticky: mul/div exceeded MD_TIMEOUT
- stall_count  out  CNT_W  saturating count of cycles with pc_write=0

## Operation
- FSM states: RUN, MD_WAIT. Outputs are Mealy (state + current inputs), settled within the cycle.
- Default (RUN, no event): pc_write=if_id_write=id_ex_write=1; all flushes, ex_stall = 0.
- RUN priority, highest first:
  1. md_start=1 and md_done=0: freeze.
     - pc_write=if_id_write=id_ex_write=0, ex_mem_flush=1.
     - Next state MD_WAIT; timeout counter cleared to 0.
     - md_start=md_done=1 together: no freeze, stay RUN.
  2. ex_jump!=0 or ex_branch_taken=1: if_id_flush=id_ex_flush=1.
     - Enables stay 1, ex_stall=0.
     - Load-use in the same cycle is ignored, because the ID instruction is squashed.
  3. Load-use: ex_mem_read=1, ex_rt!=0, and either ex_rt==id_rs or (id_uses_rt=1 and ex_rt==id_rt).
     - pc_write=if_id_write=0, ex_stall=1, id_ex_write=1.
     - One bubble only; stays RUN.
- MD_WAIT:
  - md_done=0: freeze outputs as in RUN item 1; timeout counter +1.
    - If counter reaches MD_TIMEOUT-1 this cycle: md_timeout←1, next RUN (abort; the pipeline resumes).
  - md_done=1: default outputs (the pipeline advances and captures the result); next RUN.
  - ex_jump, ex_branch_taken, load-use, md_start: ignored.
- md_timeout is sticky; it clears only on reset.
- stall_count +1 on every rising edge where pc_write=0; saturates at 2^CNT_W-1 and never wraps.
- Comparisons of register 0: a load to $zero never stalls.

## Timing
- Reset (rst=0, asynchronous):
  - State RUN; timeout counter 0; md_timeout=0; stall_count=0.
  - Outputs forced, independent of inputs: pc_write=if_id_write=id_ex_write=1; ex_stall, all flushes = 0.
- Reset release: normal operation from the first rising edge with rst=1.
- Reset mid-MD_WAIT: immediate return to RUN. The partially counted timeout is discarded and stall_count is cleared.
- Hazard outputs are combinational in the same cycle as the causing inputs; the downstream registers act on the next edge.
- Load-use costs exactly 1 cycle. A mul/div of N cycles (md_done asserted N-1 cycles after md_start) costs N-1 stall cycles.
- Timeout: MD_WAIT with md_done held 0 exits after exactly MD_TIMEOUT cycles in MD_WAIT. md_timeout is visible starting the next cycle.

## Test plan
- Reset: drive random inputs with rst=0 -> all enables 1, all flushes/ex_stall 0, stall_count=0, md_timeout=0.
- Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 -> one cycle of pc_write=0, if_id_write=0, ex_stall=1.
  - Same stimulus with ex_rt=0 -> no stall.
  - ex_rt=5, id_rt=5, id_uses_rt=0 -> no stall.
- Flush priority: ex_branch_taken=1 concurrent with a load-use match -> if_id_flush=id_ex_flush=1, ex_stall=0, pc_write=1.
- Mul/div: md_start pulse, md_done 4 cycles later -> 4 frozen cycles, ex_mem_flush=1 each; release on the md_done cycle; stall_count=4.
- Timeout: MD_TIMEOUT=8, md_start, md_done never -> 8 freeze cycles then RUN; md_timeout=1 and stays 1 across a subsequent normal mul/div.
- Saturation: CNT_W=4, 20 consecutive load-use stalls -> stall_count stops at 15. Asserting rst mid-MD_WAIT -> RUN, counters 0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: ID/EX hazard inputs, mul/div
// handshake, and the enables, flushes and status the controller drives back.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [4:0]       ex_rt;
    logic [1:0]       ex_jump;
    logic             ex_branch_taken;
    logic             md_start;
    logic             md_done;

    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_write;
    logic             ex_stall;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             md_timeout;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_jump,
               ex_branch_taken, md_start, md_done,
        input  pc_write, if_id_write, id_ex_write, ex_stall, if_id_flush,
               id_ex_flush, ex_mem_flush, md_timeout, stall_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_jump,
               ex_branch_taken, md_start, md_done,
        output pc_write, if_id_write, id_ex_write, ex_stall, if_id_flush,
               id_ex_flush, ex_mem_flush, md_timeout, stall_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// MIPS32 five-stage hazard/stall controller: load-use bubbles, control-transfer
// flushes, mul/div freeze with sticky timeout, and a saturating stall counter.
module hazard_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  bus
);
    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] MD_LAST = CNT_W'(MD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             timeout_q, timeout_d;

    logic load_use;
    logic ctrl_xfer;
    logic pc_write, if_id_write, id_ex_write, ex_stall;
    logic if_id_flush, id_ex_flush, ex_mem_flush;

    // A load into $zero produces no real dependency.
    assign load_use  = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                       ((bus.ex_rt == bus.id_rs) ||
                        (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
    assign ctrl_xfer = (bus.ex_jump != 2'b00) || bus.ex_branch_taken;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        md_cnt_d     = md_cnt_q;
        timeout_d    = timeout_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_stall     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;

        // While rst is low the outputs keep their defaults whatever the inputs.
        if (rst) begin
            case (state_q)
                RUN: begin
                    if (bus.md_start && !bus.md_done) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_flush = 1'b1;
                        md_cnt_d     = '0;
                        state_d      = MD_WAIT;
                    end else if (ctrl_xfer) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        ex_stall    = 1'b1;
                    end
                end
                MD_WAIT: begin
                    if (!bus.md_done) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_flush = 1'b1;
                        md_cnt_d     = md_cnt_q + 1'b1;
                        // md_cnt_q holds the number of MD_WAIT cycles already
                        // spent, so this is the MD_TIMEOUT-th one: abort.
                        if (md_cnt_q == MD_LAST) begin
                            timeout_d = 1'b1;
                            state_d   = RUN;
                        end
                    end else begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end

        stall_cnt_d = stall_cnt_q;
        if (!pc_write && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.pc_write     = pc_write;
    assign bus.if_id_write  = if_id_write;
    assign bus.id_ex_write  = id_ex_write;
    assign bus.ex_stall     = ex_stall;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_flush  = id_ex_flush;
    assign bus.ex_mem_flush = ex_mem_flush;
    assign bus.md_timeout   = timeout_q;
    assign bus.stall_count  = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: single-cycle vector table, hand-written
// mul/div, timeout, saturation and reset sequences, then randomized traffic.
module tb_hazard_ctrl;
    localparam int MD_TIMEOUT = 8;
    localparam int CNT_W      = 4;
    localparam int CNT_SAT    = (1 << CNT_W) - 1;

    // Output order: {pc_write, if_id_write, id_ex_write, ex_stall,
    //                if_id_flush, id_ex_flush, ex_mem_flush}
    localparam logic [6:0] DEF = 7'b1110000;
    localparam logic [6:0] FRZ = 7'b0000001;
    localparam logic [6:0] FLU = 7'b1110110;
    localparam logic [6:0] LU  = 7'b0011000;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    hazard_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       mem_read;
        logic [4:0] ex_rt;
        logic [1:0] jump;
        logic       br;
        logic       mds;
        logic       mdd;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[12];

    // Reference model state: pipeline mode, cycles spent waiting, flags.
    bit m_in_md;
    int m_wait;
    bit m_tflag;
    int m_stalls;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] outs();
        return {hz.pc_write, hz.if_id_write, hz.id_ex_write, hz.ex_stall,
                hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush};
    endfunction

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                         input logic mr, input logic [4:0] er, input logic [1:0] j,
                         input logic br, input logic ms, input logic md);
        hz.id_rs = rs; hz.id_rt = rt; hz.id_uses_rt = ur;
        hz.ex_mem_read = mr; hz.ex_rt = er; hz.ex_jump = j;
        hz.ex_branch_taken = br; hz.md_start = ms; hz.md_done = md;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        m_in_md  = 1'b0;
        m_wait   = 0;
        m_tflag  = 1'b0;
        m_stalls = 0;
    endtask

    function automatic logic [6:0] model_out();
        bit dep;
        if (!rst) return DEF;
        if (m_in_md) return hz.md_done ? DEF : FRZ;
        if (hz.md_start && !hz.md_done) return FRZ;
        if (hz.ex_jump != 2'd0 || hz.ex_branch_taken) return FLU;
        dep = hz.ex_mem_read && hz.ex_rt != 5'd0 &&
              (hz.ex_rt == hz.id_rs || (hz.id_uses_rt && hz.ex_rt == hz.id_rt));
        return dep ? LU : DEF;
    endfunction

    // Compare the DUT against the model in the middle of the current cycle.
    task automatic auto_check(input string tag);
        #1;
        if (!rst) model_reset();
        check({tag, " outs"}, 32'(outs()), 32'(model_out()));
        check({tag, " stall_count"}, 32'(hz.stall_count), 32'(m_stalls));
        check({tag, " md_timeout"}, 32'(hz.md_timeout), 32'(m_tflag));
    endtask

    // Advance one clock edge, updating the model from this cycle's behaviour.
    task automatic tick();
        logic [6:0] e;
        e = model_out();
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            if (!e[6] && m_stalls < CNT_SAT) m_stalls++;
            if (!m_in_md) begin
                if (hz.md_start && !hz.md_done) begin
                    m_in_md = 1'b1;
                    m_wait  = 0;
                end
            end else if (hz.md_done) begin
                m_in_md = 1'b0;
            end else begin
                m_wait++;
                if (m_wait == MD_TIMEOUT) begin
                    m_in_md = 1'b0;
                    m_tflag = 1'b1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic full_reset();
        idle();
        rst = 1'b0;
        #1;
        model_reset();
        rst = 1'b1;
    endtask

    function automatic vec_t mk(input string n, input logic r, input logic [4:0] rs,
                                input logic [4:0] rt, input logic ur, input logic mr,
                                input logic [4:0] er, input logic [1:0] j, input logic br,
                                input logic ms, input logic md, input logic [6:0] e);
        vec_t v;
        v.name = n; v.rst = r; v.rs = rs; v.rt = rt; v.uses_rt = ur; v.mem_read = mr;
        v.ex_rt = er; v.jump = j; v.br = br; v.mds = ms; v.mdd = md; v.exp = e;
        return v;
    endfunction

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst   = 1'b0;
        idle();
        model_reset();

        vecs[0]  = mk("idle",          1, 5'd0, 5'd0, 0, 0, 5'd0, 2'd0, 0, 0, 0, DEF);
        vecs[1]  = mk("lu_rs",         1, 5'd5, 5'd0, 0, 1, 5'd5, 2'd0, 0, 0, 0, LU);
        vecs[2]  = mk("lu_zero",       1, 5'd0, 5'd0, 1, 1, 5'd0, 2'd0, 0, 0, 0, DEF);
        vecs[3]  = mk("lu_rt_unused",  1, 5'd3, 5'd5, 0, 1, 5'd5, 2'd0, 0, 0, 0, DEF);
        vecs[4]  = mk("lu_rt_used",    1, 5'd3, 5'd5, 1, 1, 5'd5, 2'd0, 0, 0, 0, LU);
        vecs[5]  = mk("br_over_lu",    1, 5'd5, 5'd0, 0, 1, 5'd5, 2'd0, 1, 0, 0, FLU);
        vecs[6]  = mk("jump",          1, 5'd1, 5'd2, 1, 0, 5'd7, 2'd2, 0, 0, 0, FLU);
        vecs[7]  = mk("md_issue",      1, 5'd0, 5'd0, 0, 0, 5'd0, 2'd0, 0, 1, 0, FRZ);
        vecs[8]  = mk("md_same_cycle", 1, 5'd0, 5'd0, 0, 0, 5'd0, 2'd0, 0, 1, 1, DEF);
        vecs[9]  = mk("md_over_br",    1, 5'd0, 5'd0, 0, 0, 5'd0, 2'd1, 1, 1, 0, FRZ);
        vecs[10] = mk("rst_forced",    0, 5'd9, 5'd9, 1, 1, 5'd9, 2'd3, 1, 1, 0, DEF);
        vecs[11] = mk("md_over_lu",    1, 5'd4, 5'd0, 0, 1, 5'd4, 2'd0, 0, 1, 0, FRZ);

        // Reset held with random inputs: outputs forced, counters clear.
        for (int i = 0; i < 4; i++) begin
            drive(5'($urandom_range(3)), 5'($urandom_range(3)), 1'($urandom),
                  1'($urandom), 5'($urandom_range(3)), 2'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
            #2;
            check("reset outs", 32'(outs()), 32'(DEF));
            check("reset stall_count", 32'(hz.stall_count), 0);
            check("reset md_timeout", 32'(hz.md_timeout), 0);
            @(negedge clk);
        end

        // Table: each vector is applied from a freshly reset RUN state.
        for (int i = 0; i < 12; i++) begin
            full_reset();
            drive(vecs[i].rs, vecs[i].rt, vecs[i].uses_rt, vecs[i].mem_read,
                  vecs[i].ex_rt, vecs[i].jump, vecs[i].br, vecs[i].mds, vecs[i].mdd);
            rst = vecs[i].rst;
            #1;
            check({"vec ", vecs[i].name}, 32'(outs()), 32'(vecs[i].exp));
            @(negedge clk);
        end
        full_reset();
        @(negedge clk);

        // Mul/div with md_done four cycles after issue: four frozen cycles.
        full_reset();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        auto_check("md issue");
        check("md issue frz", 32'(outs()), 32'(FRZ));
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 2'd1, 1'b1, 1'b1, 1'b0);
            auto_check("md wait");
            check("md wait frz", 32'(outs()), 32'(FRZ));
            tick();
        end
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        auto_check("md done");
        check("md done release", 32'(outs()), 32'(DEF));
        tick();
        idle();
        auto_check("md after");
        check("md stall_count", 32'(hz.stall_count), 4);
        tick();

        // Timeout: md_done never arrives; exit after MD_TIMEOUT waiting cycles.
        full_reset();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        auto_check("to issue");
        tick();
        hz.md_start = 1'b0;
        for (int i = 0; i < MD_TIMEOUT; i++) begin
            auto_check("to wait");
            check("to wait frz", 32'(outs()), 32'(FRZ));
            check("to flag low", 32'(hz.md_timeout), 0);
            tick();
        end
        auto_check("to exit");
        check("to exit run", 32'(outs()), 32'(DEF));
        check("to flag set", 32'(hz.md_timeout), 1);
        check("to stall_count", 32'(hz.stall_count), 32'(MD_TIMEOUT + 1));
        hz.md_start = 1'b1;
        auto_check("to md2 issue");
        tick();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        auto_check("to md2 done");
        tick();
        idle();
        auto_check("to md2 after");
        check("to flag sticky", 32'(hz.md_timeout), 1);

        // Saturation: 20 consecutive load-use stalls on a 4-bit counter.
        full_reset();
        drive(5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 2'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            auto_check("sat lu");
            tick();
        end
        check("sat stall_count", 32'(hz.stall_count), 32'(CNT_SAT));

        // Reset asserted in the middle of MD_WAIT.
        full_reset();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0);
        auto_check("mr issue");
        tick();
        hz.md_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            auto_check("mr wait");
            tick();
        end
        rst = 1'b0;
        auto_check("mr in reset");
        check("mr reset outs", 32'(outs()), 32'(DEF));
        check("mr reset stall_count", 32'(hz.stall_count), 0);
        rst = 1'b1;
        auto_check("mr released");
        check("mr back in run", 32'(outs()), 32'(DEF));
        tick();

        // Randomized traffic with occasional asynchronous resets.
        full_reset();
        for (int i = 0; i < 800; i++) begin
            drive(5'($urandom_range(3)), 5'($urandom_range(3)), 1'($urandom),
                  1'($urandom_range(1)), 5'($urandom_range(3)),
                  ($urandom_range(9) == 0) ? 2'($urandom_range(3, 1)) : 2'd0,
                  1'($urandom_range(9) == 0), 1'($urandom_range(6) == 0),
                  1'($urandom_range(3) == 0));
            rst = ($urandom_range(99) != 0);
            auto_check("rand");
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
